// File: rtl/tlc_signal_monitor.sv
// Lamp decoder and sequencing monitor for the traffic-light controller heads.
// Any illegal code, conflict, bad step or short yellow latches a fault and flashes both reds.
module tlc_signal_monitor #(
  parameter int MIN_YELLOW = 150000000,
  parameter int FLASH_HALF = 25000000,
  parameter int CW         = 31
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic [1:0] highwaySignal,
  input  logic [1:0] farmSignal,
  output logic [2:0] hwyLamp,
  output logic [2:0] farmLamp,
  output logic       fault,
  output logic [2:0] faultCode
);

  localparam logic [1:0] SIG_G = 2'b11;
  localparam logic [1:0] SIG_Y = 2'b10;
  localparam logic [1:0] SIG_R = 2'b00;
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [CW-1:0] MIN_Y    = CW'(MIN_YELLOW);
  localparam logic [CW-1:0] FLASH_TC = CW'(FLASH_HALF - 1);

  typedef enum logic {MONITOR = 1'b0, FAULT = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [1:0]    cur_h_q, cur_h_d, prev_h_q, prev_h_d;
  logic [1:0]    cur_f_q, cur_f_d, prev_f_q, prev_f_d;
  logic [CW-1:0] ycnt_q, ycnt_d;
  logic [CW-1:0] flash_q, flash_d;
  logic [2:0]    hwy_lamp_q, hwy_lamp_d, farm_lamp_q, farm_lamp_d;
  logic          fault_q, fault_d;
  logic [2:0]    fault_code_q, fault_code_d;
  logic [2:0]    viol;

  function automatic logic [2:0] decode(input logic [1:0] s);
    case (s)
      SIG_G:   decode = 3'b001;
      SIG_Y:   decode = 3'b010;
      SIG_R:   decode = 3'b100;
      default: decode = 3'b000;
    endcase
  endfunction

  function automatic logic bad_step(input logic [1:0] p, input logic [1:0] c);
    bad_step = (p == SIG_G && c == SIG_R) || (p == SIG_Y && c == SIG_G) ||
               (p == SIG_R && c == SIG_Y);
  endfunction

  function automatic logic yel_to_red(input logic [1:0] p, input logic [1:0] c);
    yel_to_red = (p == SIG_Y) && (c == SIG_R);
  endfunction

  // Lowest fault code wins when several checks hold together.
  always_comb begin
    viol = 3'b000;
    if (cur_h_q == 2'b01 || cur_f_q == 2'b01)
      viol = 3'b001;
    else if (cur_h_q != SIG_R && cur_f_q != SIG_R)
      viol = 3'b010;
    else if (bad_step(prev_h_q, cur_h_q) || bad_step(prev_f_q, cur_f_q))
      viol = 3'b011;
    else if ((yel_to_red(prev_h_q, cur_h_q) || yel_to_red(prev_f_q, cur_f_q)) &&
             ycnt_q < MIN_Y)
      viol = 3'b100;
  end

  always_comb begin
    cur_h_d      = highwaySignal;
    cur_f_d      = farmSignal;
    prev_h_d     = cur_h_q;
    prev_f_d     = cur_f_q;
    ycnt_d       = '0;
    state_d      = state_q;
    flash_d      = flash_q;
    hwy_lamp_d   = hwy_lamp_q;
    farm_lamp_d  = farm_lamp_q;
    fault_d      = fault_q;
    fault_code_d = fault_code_q;

    if (cur_h_q == SIG_Y || cur_f_q == SIG_Y)
      ycnt_d = (ycnt_q < MIN_Y) ? ycnt_q + 1'b1 : ycnt_q;

    case (state_q)
      MONITOR: begin
        if (viol != 3'b000) begin
          state_d      = FAULT;
          fault_d      = 1'b1;
          fault_code_d = viol;
          hwy_lamp_d   = LAMP_RED;
          farm_lamp_d  = LAMP_RED;
          flash_d      = '0;
        end else begin
          hwy_lamp_d  = decode(cur_h_q);
          farm_lamp_d = decode(cur_f_q);
        end
      end
      default: begin
        // Both reds share one phase; the highway red bit carries it.
        if (flash_q == FLASH_TC) begin
          flash_d     = '0;
          hwy_lamp_d  = {~hwy_lamp_q[2], 2'b00};
          farm_lamp_d = {~hwy_lamp_q[2], 2'b00};
        end else begin
          flash_d = flash_q + 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q      <= MONITOR;
      cur_h_q      <= SIG_R;
      cur_f_q      <= SIG_R;
      prev_h_q     <= SIG_R;
      prev_f_q     <= SIG_R;
      ycnt_q       <= '0;
      flash_q      <= '0;
      hwy_lamp_q   <= LAMP_RED;
      farm_lamp_q  <= LAMP_RED;
      fault_q      <= 1'b0;
      fault_code_q <= 3'b000;
    end else begin
      state_q      <= state_d;
      cur_h_q      <= cur_h_d;
      cur_f_q      <= cur_f_d;
      prev_h_q     <= prev_h_d;
      prev_f_q     <= prev_f_d;
      ycnt_q       <= ycnt_d;
      flash_q      <= flash_d;
      hwy_lamp_q   <= hwy_lamp_d;
      farm_lamp_q  <= farm_lamp_d;
      fault_q      <= fault_d;
      fault_code_q <= fault_code_d;
    end
  end

  assign hwyLamp   = hwy_lamp_q;
  assign farmLamp  = farm_lamp_q;
  assign fault     = fault_q;
  assign faultCode = fault_code_q;

endmodule

// File: tb/tb_tlc_signal_monitor.sv
// Scoreboard bench for tlc_signal_monitor: an input-indexed reference model queues
// the expected lamp/fault word for each edge and the bench compares after every edge.
module tb_tlc_signal_monitor;

  localparam int MINY = 6;
  localparam int FH   = 4;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic [1:0] hs = 2'b00;
  logic [1:0] fs = 2'b00;
  logic [2:0] hwyLamp, farmLamp, faultCode;
  logic       fault;

  tlc_signal_monitor #(.MIN_YELLOW(MINY), .FLASH_HALF(FH), .CW(8)) dut (
    .Clk(Clk), .Rst(Rst), .highwaySignal(hs), .farmSignal(fs),
    .hwyLamp(hwyLamp), .farmLamp(farmLamp), .fault(fault), .faultCode(faultCode)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] h;
    logic [2:0] f;
    logic       flt;
    logic [2:0] code;
  } exp_t;

  exp_t  sb[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  string tag = "init";

  logic [1:0] m_ph, m_pf;
  int         m_yrun, m_age;
  bit         m_flt;
  logic [2:0] m_code;

  task automatic chk(input string t, input logic [15:0] obs, input logic [15:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", t, obs, expv, $time);
    end
  endtask

  function automatic logic [2:0] dec(input logic [1:0] s);
    case (s)
      2'b11:   return 3'b001;
      2'b10:   return 3'b010;
      2'b00:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic bit ill(input logic [1:0] p, input logic [1:0] c);
    return (p == 2'b11 && c == 2'b00) || (p == 2'b10 && c == 2'b11) ||
           (p == 2'b00 && c == 2'b10);
  endfunction

  task automatic model_reset();
    exp_t e;
    m_ph = 2'b00; m_pf = 2'b00; m_yrun = 0; m_flt = 0; m_code = 3'b000; m_age = 0;
    sb.delete();
    e.h = 3'b100; e.f = 3'b100; e.flt = 1'b0; e.code = 3'b000;
    sb.push_back(e);
  endtask

  // Expected outputs one edge after this input's sampling edge.
  task automatic push_exp(input logic [1:0] h, input logic [1:0] f);
    exp_t       e;
    logic [2:0] v;
    bit         red;
    v = 3'b000;
    if (!m_flt) begin
      if (h == 2'b01 || f == 2'b01) v = 3'b001;
      else if (h != 2'b00 && f != 2'b00) v = 3'b010;
      else if (ill(m_ph, h) || ill(m_pf, f)) v = 3'b011;
      else if (((m_ph == 2'b10 && h == 2'b00) || (m_pf == 2'b10 && f == 2'b00)) &&
               m_yrun < MINY) v = 3'b100;
      if (v != 3'b000) begin
        m_flt = 1; m_code = v; m_age = 0;
        e.h = 3'b100; e.f = 3'b100;
      end else begin
        e.h = dec(h); e.f = dec(f);
      end
    end else begin
      m_age++;
      red = ((m_age / FH) % 2) == 0;
      e.h = red ? 3'b100 : 3'b000;
      e.f = e.h;
    end
    e.flt  = m_flt;
    e.code = m_code;
    if (h == 2'b10 || f == 2'b10) m_yrun = (m_yrun < MINY) ? m_yrun + 1 : MINY;
    else m_yrun = 0;
    m_ph = h; m_pf = f;
    sb.push_back(e);
  endtask

  task automatic step(input logic [1:0] h, input logic [1:0] f);
    exp_t e;
    hs = h; fs = f;
    push_exp(h, f);
    @(posedge Clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 16'd1, 16'd0);
    end else begin
      e = sb.pop_front();
      chk(tag, {6'b0, hwyLamp, farmLamp, fault, faultCode}, 16'(e));
    end
  endtask

  task automatic hold(input logic [1:0] h, input logic [1:0] f, input int n);
    for (int i = 0; i < n; i++) step(h, f);
  endtask

  task automatic do_reset();
    #3;
    Rst = 1'b1;
    #1;
    chk({tag, "_rst_lamps"}, {10'b0, hwyLamp, farmLamp}, 16'b100100);
    chk({tag, "_rst_fault"}, {12'b0, fault, faultCode}, 16'd0);
    #2;
    Rst = 1'b0;
    hs = 2'b00; fs = 2'b00;
    model_reset();
  endtask

  task automatic legal_cycle(input int hy, input int fy);
    hold(2'b00, 2'b00, 2);
    hold(2'b11, 2'b00, 10);
    hold(2'b10, 2'b00, hy);
    hold(2'b00, 2'b00, 3);
    hold(2'b00, 2'b11, 5);
    hold(2'b00, 2'b10, fy);
    hold(2'b00, 2'b00, 4);
  endtask

  initial begin
    @(posedge Clk);
    #1;
    tag = "reset";
    do_reset();

    tag = "legal";
    legal_cycle(MINY, MINY);
    chk("legal_nofault", {15'b0, fault}, 16'd0);

    tag = "short";
    hold(2'b11, 2'b00, 3);
    hold(2'b10, 2'b00, MINY - 1);
    hold(2'b00, 2'b00, 12);
    chk("short_code", {13'b0, faultCode}, 16'd4);
    tag = "rst_midfault";
    do_reset();

    tag = "conflict";
    hold(2'b11, 2'b00, 2);
    hold(2'b11, 2'b11, 1);
    hold(2'b00, 2'b00, 6);
    chk("conflict_code", {13'b0, faultCode}, 16'd2);
    do_reset();

    tag = "prio";
    hold(2'b11, 2'b00, 3);
    step(2'b01, 2'b11);
    step(2'b11, 2'b00);
    hold(2'b00, 2'b00, 5);
    chk("prio_code", {13'b0, faultCode}, 16'd1);
    do_reset();

    tag = "ill_hwy";
    hold(2'b11, 2'b00, 2);
    hold(2'b00, 2'b00, 4);
    chk("ill_hwy_code", {13'b0, faultCode}, 16'd3);
    do_reset();

    tag = "ill_farm";
    hold(2'b00, 2'b10, 4);
    chk("ill_farm_code", {13'b0, faultCode}, 16'd3);
    do_reset();

    tag = "legal2";
    legal_cycle(MINY + 3, MINY);
    chk("legal2_nofault", {15'b0, fault}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
